// File: rtl/multi_field_display_if.sv
// multi_field_display_if
// Groups the load handshake, value bus, decimal-point request and the
// multiplexed display pins of multi_field_display.
//   Values     : FIELDS packed unsigned values, field f at [f*NUM_WIDTH +: NUM_WIDTH]
//   Load       : capture request (ignored while Busy)
//   BlankZeros : leading-zero blanking mode, captured with Load
//   DpMask     : live per-digit decimal-point request, 1 = on
//   out7/dp    : active-low segments {a..g} and decimal point
//   en_out     : active-low one-hot digit enables
//   Busy/Done  : conversion in progress / one-cycle commit pulse
// master = producer of values and consumer of the pins, slave = the driver.
interface multi_field_display_if #(
  parameter int FIELDS       = 2,
  parameter int FIELD_DIGITS = 4,
  parameter int NUM_WIDTH    = 14
);
  localparam int DIGITS = FIELDS * FIELD_DIGITS;

  logic [FIELDS*NUM_WIDTH-1:0] Values;
  logic                        Load;
  logic                        BlankZeros;
  logic [DIGITS-1:0]           DpMask;
  logic [6:0]                  out7;
  logic                        dp;
  logic [DIGITS-1:0]           en_out;
  logic                        Busy;
  logic                        Done;

  modport master (
    output Values, Load, BlankZeros, DpMask,
    input  out7, dp, en_out, Busy, Done
  );

  modport slave (
    input  Values, Load, BlankZeros, DpMask,
    output out7, dp, en_out, Busy, Done
  );
endinterface

// File: rtl/multi_field_display.sv
// multi_field_display
// Multiplexed active-low 7-segment driver showing FIELDS unsigned values as
// FIELD_DIGITS-wide decimal fields. A sequential double-dabble converter
// (one bit per clock, one field after another) produces BCD; results are
// committed to the display registers in a single clock so the display never
// shows a partially converted frame.
// Ports:
//   Clk : system clock, rising edge
//   Rst : synchronous active-high reset
//   bus : multi_field_display_if.slave (values, handshake, display pins)
//
// state   | meaning
// IDLE    | waiting for Load, display shows last committed frame
// CONVERT | one double-dabble step per clock on field fld
// COMMIT  | copy decoded segments into display registers, pulse Done
module multi_field_display #(
  parameter int FIELDS       = 2,
  parameter int FIELD_DIGITS = 4,
  parameter int NUM_WIDTH    = 14,
  parameter int REFRESH_BITS = 17
) (
  input logic                   Clk,
  input logic                   Rst,
  multi_field_display_if.slave  bus
);
  localparam int DIGITS = FIELDS * FIELD_DIGITS;
  localparam int BCD_W  = 4 * FIELD_DIGITS;
  localparam int F_W    = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int B_W    = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;
  localparam int D_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LIMIT  = 10 ** FIELD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t state, state_nxt;
  logic   load_accept, field_end, last_field;

  logic [FIELDS-1:0][NUM_WIDTH-1:0] shadow;
  logic                             blank_mode;
  logic [FIELDS-1:0]                ovf;
  logic [F_W-1:0]                   fld, fld_nxt;
  logic [B_W-1:0]                   bit_cnt;
  logic [NUM_WIDTH-1:0]             bin;
  logic [BCD_W-1:0]                 bcd, bcd_adj, bcd_shift;
  logic [FIELDS-1:0][BCD_W-1:0]     field_bcd;
  logic [DIGITS-1:0][6:0]           disp, disp_nxt;
  logic                             done_q;

  logic [REFRESH_BITS-1:0] pres;
  logic [D_W-1:0]          idx;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [DIGITS-1:0]       en_q;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign field_end  = (bit_cnt == B_W'(NUM_WIDTH - 1));
  assign last_field = (fld == F_W'(FIELDS - 1));
  assign fld_nxt    = last_field ? '0 : fld + 1'b1;

  always_comb begin
    state_nxt   = state;
    load_accept = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Load) begin
          load_accept = 1'b1;
          state_nxt   = CONVERT;
        end
      end
      CONVERT: begin
        if (field_end && last_field) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < FIELD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digits above the field width are dropped; such values are shown as
  // dashes anyway, so only the low FIELD_DIGITS nibbles need to be exact.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin[NUM_WIDTH-1]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow     <= '0;
      blank_mode <= 1'b0;
      ovf        <= '0;
      fld        <= '0;
      bit_cnt    <= '0;
      bin        <= '0;
      bcd        <= '0;
      field_bcd  <= '0;
      disp       <= {DIGITS{SEG_BLANK}};
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == COMMIT);
      if (load_accept) begin
        shadow     <= bus.Values;
        blank_mode <= bus.BlankZeros;
        for (int f = 0; f < FIELDS; f++) begin
          ovf[f] <= (32'(bus.Values[f*NUM_WIDTH +: NUM_WIDTH]) >= 32'(LIMIT));
        end
        fld     <= '0;
        bit_cnt <= '0;
        bin     <= bus.Values[NUM_WIDTH-1:0];
        bcd     <= '0;
      end else if (state == CONVERT) begin
        if (field_end) begin
          field_bcd[fld] <= bcd_shift;
          bcd            <= '0;
          bit_cnt        <= '0;
          fld            <= fld_nxt;
          bin            <= shadow[fld_nxt];
        end else begin
          bcd     <= bcd_shift;
          bit_cnt <= bit_cnt + 1'b1;
          bin     <= bin << 1;
        end
      end
      if (state == COMMIT) disp <= disp_nxt;
    end
  end

  // Segment decode per field: dash on overflow, otherwise blank zeros above
  // the most significant non-zero digit (digit 0 always shown).
  logic       seen_nz;
  logic [3:0] nib;
  always_comb begin
    disp_nxt = '0;
    seen_nz  = 1'b0;
    nib      = '0;
    for (int f = 0; f < FIELDS; f++) begin
      seen_nz = 1'b0;
      for (int k = FIELD_DIGITS - 1; k >= 0; k--) begin
        nib = field_bcd[f][4*k +: 4];
        if (nib != 4'd0) seen_nz = 1'b1;
        if (ovf[f])
          disp_nxt[f*FIELD_DIGITS + k] = SEG_DASH;
        else if (blank_mode && !seen_nz && (k != 0))
          disp_nxt[f*FIELD_DIGITS + k] = SEG_BLANK;
        else
          disp_nxt[f*FIELD_DIGITS + k] = seg_of(nib);
      end
    end
  end

  // ---------------- scan ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pres  <= '0;
      idx   <= '0;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      en_q  <= '1;
    end else begin
      pres <= pres + 1'b1;
      if (pres == '1) idx <= (idx == D_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      en_q  <= ~(DIGITS'(1) << idx);
      seg_q <= disp[idx];
      dp_q  <= ~bus.DpMask[idx];
    end
  end

  assign bus.out7   = seg_q;
  assign bus.dp     = dp_q;
  assign bus.en_out = en_q;
  assign bus.Busy   = (state != IDLE);
  assign bus.Done   = done_q;
endmodule

// File: tb/tb_multi_field_display.sv
module tb_multi_field_display;
  localparam int FIELDS = 2;
  localparam int FD     = 4;
  localparam int NW     = 14;
  localparam int DIGITS = FIELDS * FD;

  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_field_display_if #(.FIELDS(FIELDS), .FIELD_DIGITS(FD), .NUM_WIDTH(NW)) bus ();

  multi_field_display #(.FIELDS(FIELDS), .FIELD_DIGITS(FD), .NUM_WIDTH(NW),
                        .REFRESH_BITS(2)) dut (
    .Clk(clk), .Rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int done_extra;
  logic [DIGITS*7-1:0] sb[$];

  // Independent reference: divide/modulo decimal digits.
  function automatic logic [DIGITS*7-1:0] model(input logic [FIELDS*NW-1:0] vals,
                                               input logic blank);
    logic [DIGITS*7-1:0] r;
    int v, pw;
    r = '0;
    for (int f = 0; f < FIELDS; f++) begin
      v  = int'(vals[f*NW +: NW]);
      pw = 1;
      for (int k = 0; k < FD; k++) begin
        if (v >= 10000)                   r[(f*FD+k)*7 +: 7] = 7'b1111110;
        else if (blank && k > 0 && v < pw) r[(f*FD+k)*7 +: 7] = 7'b1111111;
        else                              r[(f*FD+k)*7 +: 7] = SEG[(v / pw) % 10];
        pw = pw * 10;
      end
    end
    return r;
  endfunction

  task automatic do_load(input logic [FIELDS*NW-1:0] vals, input logic blank,
                         input bit push);
    bus.Values     = vals;
    bus.BlankZeros = blank;
    bus.Load       = 1'b1;
    if (push) sb.push_back(model(vals, blank));
    @(negedge clk);
    bus.Load = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_load: got %b expected 1", bus.Busy);
    end
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    bit found;
    found = 0;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL done_timeout: no Done within 100 cycles, expected after %0d", exp_n);
    end else begin
      if (n !== exp_n) begin
        n_fail++;
        $display("FAIL done_latency: got %0d expected %0d", n, exp_n);
      end
      n_checks++;
      if (bus.Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_at_done: got %b expected 0", bus.Busy);
      end
    end
  endtask

  // Pops the expected frame and compares every digit observed on the scan.
  task automatic check_display(input string name);
    logic [DIGITS*7-1:0] exp_v, got;
    logic [DIGITS-1:0] seen;
    exp_v = sb.pop_front();
    got = '0;
    seen = '0;
    done_extra = 0;
    @(negedge clk);
    n_checks++;
    if (bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: got %b expected 0", name, bus.Done);
    end
    for (int c = 0; c < 80 && seen != '1; c++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_extra++;
      for (int d = 0; d < DIGITS; d++) begin
        if (bus.en_out === ~(8'b1 << d)) begin
          got[d*7 +: 7] = bus.out7;
          seen[d] = 1'b1;
        end
      end
    end
    n_checks++;
    if (seen !== '1) begin
      n_fail++;
      $display("FAIL %s_scan_timeout: digits seen %b expected all", name, seen);
    end
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if (got[d*7 +: 7] !== exp_v[d*7 +: 7]) begin
        n_fail++;
        $display("FAIL %s_digit%0d: got %b expected %b", name, d, got[d*7 +: 7],
                 exp_v[d*7 +: 7]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_en;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.en_out !== 8'hFF || bus.out7 !== 7'h7F || bus.dp !== 1'b1 ||
          bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got en=%h seg=%h dp=%b busy=%b done=%b expected FF 7F 1 0 0",
                 bus.en_out, bus.out7, bus.dp, bus.Busy, bus.Done);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_en = ~(8'b1 << ((i / 4) % 8));
      n_checks++;
      if (bus.en_out !== exp_en || bus.out7 !== 7'h7F) begin
        n_fail++;
        $display("FAIL reset_scan_%0d: got en=%h seg=%h expected en=%h seg=7f",
                 i, bus.en_out, bus.out7, exp_en);
      end
    end
  endtask

  task automatic test_load_plain();
    do_load({14'd56, 14'd1234}, 1'b0, 1);
    wait_done(29);
    check_display("plain");
  endtask

  task automatic test_blanking();
    do_load({14'd0, 14'd56}, 1'b1, 1);
    wait_done(29);
    check_display("blank");
  endtask

  task automatic test_overflow();
    do_load({14'd9999, 14'd10000}, 1'b0, 1);
    wait_done(29);
    check_display("ovf");
  endtask

  task automatic test_handshake();
    do_load({14'd7, 14'd89}, 1'b1, 1);
    repeat (4) @(negedge clk);
    bus.Values = {14'd1, 14'd2};
    bus.BlankZeros = 1'b0;
    bus.Load = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
    wait_done(24);
    check_display("busy_load");
    n_checks++;
    if (done_extra !== 0) begin
      n_fail++;
      $display("FAIL busy_load_done_count: got %0d extra Done expected 0", done_extra);
    end
  endtask

  task automatic test_abort();
    do_load({14'd4321, 14'd8765}, 1'b0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", bus.Busy, bus.Done);
    end
    sb.push_back({DIGITS{7'b1111111}});
    check_display("abort");
    n_checks++;
    if (done_extra !== 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d Done pulses expected 0", done_extra);
    end
  endtask

  task automatic test_dp();
    logic exp_dp;
    int lows;
    lows = 0;
    bus.DpMask = 8'b0001_0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_dp = (bus.en_out === 8'hEF) ? 1'b0 : 1'b1;
      if (bus.dp === 1'b0) lows++;
      n_checks++;
      if (bus.dp !== exp_dp) begin
        n_fail++;
        $display("FAIL dp_%0d: got dp=%b (en=%h) expected %b", i, bus.dp, bus.en_out, exp_dp);
      end
    end
    n_checks++;
    if (lows !== 4 && lows !== 8) begin
      n_fail++;
      $display("FAIL dp_low_count: got %0d low cycles expected 4 or 8", lows);
    end
    bus.DpMask = '0;
  endtask

  initial begin
    bus.Values     = '0;
    bus.Load       = 1'b0;
    bus.BlankZeros = 1'b0;
    bus.DpMask     = '0;
    test_reset();
    test_load_plain();
    test_blanking();
    test_overflow();
    test_handshake();
    test_abort();
    test_dp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
